fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Decoupling queue between instruction memory and the decode pipeline register of the 5-stage ARM CPU. It captures each fetched instruction word with its PC and presents them in order to decode, so a stalled decode stage does not discard fetches. A taken branch flushes it in one cycle. It holds up to DEPTH entries and gives back-pressure to the fetch side when full.

## Interface
- DEPTH, 4, entry count; power of two, at least 2
- PC_W, 64, PC width
- INSTR_W, 32, instruction width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  branch taken; discard all entries
- fetch_valid  in  1  fetch_instr/fetch_pc valid this cycle
- fetch_instr  in  INSTR_W  instruction word from instruction memory
- fetch_pc  in  PC_W  PC of fetch_instr
- fetch_ready  out  1  buffer accepts a push this cycle
- dec_valid  out  1  head entry presented
- dec_instr  out  INSTR_W  head instruction
- dec_pc  out  PC_W  head PC
- dec_ready  in  1  decode consumes head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular array of DEPTH {pc, instr} entries. Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Push: fetch_valid && fetch_ready && !flush. The entry is written at wr_ptr and wr_ptr increments.
- Pop: dec_valid && dec_ready && !flush. rd_ptr increments.
- fetch_ready = (count != DEPTH). It is a function of registered state only and does not depend on dec_ready, so there is no combinational path from dec_ready to fetch_ready.
- dec_valid = (count != 0).
- When dec_valid=1, dec_instr/dec_pc show the head entry.
- When dec_valid=0, dec_instr = NOP (32'hD503201F) and dec_pc = 0.
- Simultaneous push and pop: both take effect and count is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- When full, a pop and a push cannot occur in the same cycle, because fetch_ready=0.
- Flush has priority over push and pop.
  - rd_ptr, wr_ptr and count clear to 0 at the next edge.
  - The fetch in the same cycle is dropped.
  - Entry contents are not cleared.
- Pointers wrap modulo 2·DEPTH. The array index is ptr[$clog2(DEPTH)-1:0].
- There are no named FSM states. The behaviour is fully defined by count, which takes values 0 (EMPTY), 1..DEPTH-1 (PARTIAL) and DEPTH (FULL).

## Timing
- Reset (reset=0, asynchronous):
  - pointers and count are 0, so dec_valid=0 and fetch_ready=1.
  - dec_instr=NOP, dec_pc=0.
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency without bypass: an instruction pushed at edge N is visible on dec_* after edge N, i.e. in the cycle following the push. Minimum latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle.
- Flush asserted in cycle N: dec_valid=0 in cycle N+1. The first post-flush push is accepted in cycle N+1.
- count is registered, which keeps the handshake decision combinationally short.

## Configuration
- FETCH_BUFFER_BYPASS_EN defined:
  - When count==0 and fetch_valid=1 and flush=0, dec_valid=1 and dec_instr/dec_pc = fetch_instr/fetch_pc in the same cycle.
  - If dec_ready=1 in that cycle, the entry is not written and count stays 0.
  - If dec_ready=0, it is written normally.
- FETCH_BUFFER_BYPASS_EN undefined: no fetch-to-decode combinational path; minimum latency is 1 cycle as above.

## Structure
- Shared package cpu_pkg holds:
  - constant NOP_INSTR = 32'hD503201F
  - typedef fetch_entry_t {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;}
  - default widths PC_W_DEF=64 and INSTR_W_DEF=32
- Sub-module fb_ptr holds one wrapping pointer: clk, reset, inc, clr, ptr. fetch_buffer instantiates it twice, once for read and once for write. Storage, count and output muxing stay in fetch_buffer.

## Test plan
- Reset then idle: dec_valid=0, dec_instr=D503201F, dec_pc=0, fetch_ready=1, count=0; holds for 10 cycles.
- Push PCs 0x0, 0x4, 0x8, 0xC with dec_ready=0:
  - count=4, fetch_ready=0.
  - A fifth push (PC 0x10) is refused.
  - Then dec_ready=1 pops 0x0, 0x4, 0x8, 0xC in order; count returns to 0.
- Continuous push and pop for 20 cycles (PC step 4, DEPTH=4):
  - every PC emerges exactly once, in order.
  - count steady at 1 (steady at 0 with FETCH_BUFFER_BYPASS_EN).
  - pointers wrap at least twice.
- With 3 entries held, flush=1 together with fetch_valid=1 (PC 0x40):
  - next cycle count=0 and dec_valid=0.
  - PC 0x40 never appears.
  - A push of 0x80 the following cycle appears as the next dec_pc.
- Assert reset=0 asynchronously mid-cycle with 2 entries held: dec_valid drops before the next clock edge and count=0.
- FETCH_BUFFER_BYPASS_EN, empty, fetch PC 0x100 with dec_ready=1: dec_pc=0x100 in the same cycle and count stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// =============================================================================
// cpu_pkg : shared CPU constants and fetch-path types
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

package cpu_pkg;

    localparam int          PC_W_DEF    = 64;
    localparam int          INSTR_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR   = 32'hD503201F;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fb_ptr.sv
// =============================================================================
// fb_ptr : wrapping queue pointer with synchronous clear (wraps modulo 2^W)
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module fb_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Clear wins over increment so a flush always lands the pointer on 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// =============================================================================
// fetch_buffer : in-order fetch-to-decode queue with single-cycle flush
// Optional macro FETCH_BUFFER_BYPASS_EN: empty-queue fetch-to-decode bypass.
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   fetch_valid,
    input  logic [INSTR_W-1:0]     fetch_instr,
    input  logic [PC_W-1:0]        fetch_pc,
    output logic                   fetch_ready,
    output logic                   dec_valid,
    output logic [INSTR_W-1:0]     dec_instr,
    output logic [PC_W-1:0]        dec_pc,
    input  logic                   dec_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];

    logic [CW-1:0] w_rd_ptr;
    logic [CW-1:0] w_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_bypass_take;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef FETCH_BUFFER_BYPASS_EN
    // A fetch into an empty queue is shown to decode immediately; it only
    // needs storing if decode does not take it this cycle.
    assign w_bypass      = w_empty & fetch_valid & ~flush;
    assign w_bypass_take = w_bypass & dec_ready;
`else
    assign w_bypass      = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign fetch_ready = ~w_full;
    assign w_push      = fetch_valid & ~w_full & ~flush & ~w_bypass_take;
    assign w_pop       = ~w_empty & dec_ready & ~flush;

    fb_ptr #(
        .W (CW)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pop),
        .clr   (flush),
        .ptr   (w_rd_ptr)
    );

    fb_ptr #(
        .W (CW)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push),
        .clr   (flush),
        .ptr   (w_wr_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Storage is left untouched by reset and flush; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[w_wr_ptr[AW-1:0]]    <= fetch_pc;
            r_instr_mem[w_wr_ptr[AW-1:0]] <= fetch_instr;
        end
    end

    always_comb begin
        dec_valid = 1'b0;
        dec_instr = INSTR_W'(NOP_INSTR);
        dec_pc    = '0;
        if (!w_empty) begin
            dec_valid = 1'b1;
            dec_instr = r_instr_mem[w_rd_ptr[AW-1:0]];
            dec_pc    = r_pc_mem[w_rd_ptr[AW-1:0]];
        end else if (w_bypass) begin
            dec_valid = 1'b1;
            dec_instr = fetch_instr;
            dec_pc    = fetch_pc;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// =============================================================================
// tb_fetch_buffer : scoreboard bench for fetch_buffer (DEPTH=4)
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_fetch_buffer;

    localparam int DEPTH = 4;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic [63:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic [2:0]  count;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] sb_q [$];

    fetch_buffer #(
        .DEPTH   (DEPTH),
        .PC_W    (64),
        .INSTR_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hE1A0_0000 ^ pc[31:0] ^ {pc[15:0], 16'h5A5A};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the queue model, then
    // retire this cycle's handshakes into the model.
    task automatic step(input logic fv, input logic [63:0] pc, input logic dr, input logic fl);
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        logic        bp;
        @(negedge clk);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = instr_of(pc);
        dec_ready   = dr;
        flush       = fl;
        #1;
        bp        = BYPASS && (sb_q.size() == 0) && fv && !fl;
        exp_valid = (sb_q.size() != 0) || bp;
        if (sb_q.size() != 0) begin
            exp_pc    = sb_q[0];
            exp_instr = instr_of(sb_q[0]);
        end else if (bp) begin
            exp_pc    = pc;
            exp_instr = instr_of(pc);
        end else begin
            exp_pc    = 64'h0;
            exp_instr = 32'hD503201F;
        end
        check_val("count", 64'(count), 64'(sb_q.size()));
        check_val("fetch_ready", 64'(fetch_ready), 64'(sb_q.size() != DEPTH));
        check_val("dec_valid", 64'(dec_valid), 64'(exp_valid));
        check_val("dec_pc", dec_pc, exp_pc);
        check_val("dec_instr", 64'(dec_instr), 64'(exp_instr));
        if (fv && (sb_q.size() != DEPTH) && !fl) sb_q.push_back(pc);
        if (exp_valid && dr && !fl) void'(sb_q.pop_front());
        if (fl) sb_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // reset then idle
        for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 1'b0, 1'b0);

        // fill to full, refused fifth push, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 64'(4 * i), 1'b0, 1'b0);
        step(1'b1, 64'h10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // streaming push/pop, pointers wrap several times
        for (int i = 0; i < 20; i++) step(1'b1, 64'h200 + 64'(4 * i), 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // flush with a concurrent fetch that must be dropped
        for (int i = 0; i < 3; i++) step(1'b1, 64'h300 + 64'(4 * i), 1'b0, 1'b0);
        step(1'b1, 64'h40, 1'b0, 1'b1);
        step(1'b1, 64'h80, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // asynchronous reset with two entries held
        step(1'b1, 64'h500, 1'b0, 1'b0);
        step(1'b1, 64'h504, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_val("async_rst_dec_valid", 64'(dec_valid), 64'h0);
        check_val("async_rst_count", 64'(count), 64'h0);
        check_val("async_rst_dec_instr", 64'(dec_instr), 64'hD503201F);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // empty-queue fetch with decode ready (same-cycle when bypass is built in)
        step(1'b1, 64'h100, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);

        check_val("scoreboard_drained", 64'(sb_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
